// File: rtl/nano_risk_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : nano_risk_loader_if
//  Purpose  : Bundles the byte stream, the memory write port, the core
//             control/status lines and the loader status outputs.
//  Modports : master - the loader (accepts the stream, drives the memories
//                      and the core reset, reports status)
//             slave  - the environment (stream source, memories, core)
//  Revision : 1.0 - initial release
// ============================================================================
interface nano_risk_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       wr_en;
    logic       wr_sel;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       core_rst_n;
    logic       core_done;
    logic [7:0] core_result;
    logic [7:0] result;
    logic       result_valid;
    logic       running;
    logic [1:0] err_code;

    modport master (
        input  in_data, in_valid, core_done, core_result,
        output in_ready, wr_en, wr_sel, wr_addr, wr_data,
        output core_rst_n, result, result_valid, running, err_code
    );

    modport slave (
        output in_data, in_valid, core_done, core_result,
        input  in_ready, wr_en, wr_sel, wr_addr, wr_data,
        input  core_rst_n, result, result_valid, running, err_code
    );
endinterface
`default_nettype wire

// File: rtl/nano_risk_loader.sv
`default_nettype none
// ============================================================================
//  Module   : nano_risk_loader
//  Purpose  : Program loader and run controller for the nanoRisk core.
//             Parses framed commands from a byte stream, writes payload
//             bytes straight into instruction/data memory, releases and
//             re-holds the core and captures its result on completion.
//  Ports    : clk  - single clock for loader and core
//             rst  - asynchronous, active-low reset
//             bus  - nano_risk_loader_if.master (stream, write port,
//                    core control/status, loader status)
//  Revision : 1.0 - initial release
// ============================================================================
module nano_risk_loader (
    input  wire logic           clk,
    input  wire logic           rst,
    nano_risk_loader_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_LEN     = 3'd2,
        S_PAYLOAD = 3'd3,
        S_CSUM    = 3'd4
    } state_t;

    localparam logic [7:0] c_CMD_WR_INST = 8'h01;
    localparam logic [7:0] c_CMD_WR_DATA = 8'h02;
    localparam logic [7:0] c_CMD_RUN     = 8'h03;
    localparam logic [7:0] c_CMD_HALT    = 8'h04;

    state_t     r_state;
    state_t     w_state_nxt;

    logic       r_in_ready;
    logic       r_wr_en;
    logic       r_wr_sel;
    logic [7:0] r_wr_addr;
    logic [7:0] r_wr_data;
    logic [7:0] r_result;
    logic       r_result_valid;
    logic       r_running;
    logic [1:0] r_err;

    logic       r_sel;        // target memory of the frame in flight
    logic       r_blocked;    // frame arrived while the core was running
    logic [7:0] r_addr;       // next write address
    logic [8:0] r_cnt;        // payload bytes still to come (1..256)
    logic [7:0] r_sum;        // running checksum of ADDR, LEN and payload
    logic       r_done_hist;  // previous sample of core_done

    logic       w_accept;
    logic       w_capture;
    logic [7:0] w_sum_final;

    assign w_accept    = bus.in_valid & r_in_ready;
    assign w_capture   = r_running & bus.core_done & ~r_done_hist;
    assign w_sum_final = r_sum + bus.in_data;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_data == c_CMD_WR_INST || bus.in_data == c_CMD_WR_DATA)
                        w_state_nxt = S_ADDR;
                end
                S_ADDR:    w_state_nxt = S_LEN;
                S_LEN:     w_state_nxt = S_PAYLOAD;
                S_PAYLOAD: begin
                    if (r_cnt == 9'd1)
                        w_state_nxt = S_CSUM;
                end
                S_CSUM:    w_state_nxt = S_IDLE;
                default:   w_state_nxt = S_IDLE;
            endcase
        end
    end

    // ---------------- datapath and outputs ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_ready     <= 1'b0;
            r_wr_en        <= 1'b0;
            r_wr_sel       <= 1'b0;
            r_wr_addr      <= 8'h00;
            r_wr_data      <= 8'h00;
            r_result       <= 8'h00;
            r_result_valid <= 1'b0;
            r_running      <= 1'b0;
            r_err          <= 2'd0;
            r_sel          <= 1'b0;
            r_blocked      <= 1'b0;
            r_addr         <= 8'h00;
            r_cnt          <= 9'd0;
            r_sum          <= 8'h00;
            r_done_hist    <= 1'b0;
        end else begin
            // Stall the stream for the one cycle in which the result lands.
            r_in_ready  <= ~w_capture;
            r_wr_en     <= 1'b0;
            r_done_hist <= bus.core_done;

            if (w_accept) begin
                case (r_state)
                    S_IDLE: begin
                        case (bus.in_data)
                            c_CMD_WR_INST, c_CMD_WR_DATA: begin
                                r_err     <= 2'd0;
                                r_sel     <= bus.in_data[1];
                                r_blocked <= r_running;
                            end
                            c_CMD_RUN: begin
                                r_err <= 2'd0;
                                if (!r_running) begin
                                    r_running      <= 1'b1;
                                    r_result_valid <= 1'b0;
                                    // Pretend done was already high so a level
                                    // present at release is not a completion.
                                    r_done_hist    <= 1'b1;
                                end
                            end
                            c_CMD_HALT: begin
                                r_err     <= 2'd0;
                                r_running <= 1'b0;
                            end
                            default: r_err <= 2'd1;
                        endcase
                    end
                    S_ADDR: begin
                        r_addr <= bus.in_data;
                        r_sum  <= bus.in_data;
                    end
                    S_LEN: begin
                        // LEN of zero encodes 256 bytes.
                        r_cnt <= {(bus.in_data == 8'h00), bus.in_data};
                        r_sum <= w_sum_final;
                    end
                    S_PAYLOAD: begin
                        r_sum  <= w_sum_final;
                        r_cnt  <= r_cnt - 9'd1;
                        r_addr <= r_addr + 8'h01;
                        if (!r_blocked) begin
                            r_wr_en   <= 1'b1;
                            r_wr_sel  <= r_sel;
                            r_wr_addr <= r_addr;
                            r_wr_data <= bus.in_data;
                        end
                    end
                    S_CSUM: begin
                        if (r_blocked)
                            r_err <= 2'd3;
                        else if (w_sum_final != 8'h00)
                            r_err <= 2'd2;
                    end
                    default: ;
                endcase
            end

            // Completion overrides a HALT taken on the same edge.
            if (w_capture) begin
                r_result       <= bus.core_result;
                r_result_valid <= 1'b1;
                r_running      <= 1'b0;
            end
        end
    end

    assign bus.in_ready     = r_in_ready;
    assign bus.wr_en        = r_wr_en;
    assign bus.wr_sel       = r_wr_sel;
    assign bus.wr_addr      = r_wr_addr;
    assign bus.wr_data      = r_wr_data;
    assign bus.core_rst_n   = r_running;
    assign bus.result       = r_result;
    assign bus.result_valid = r_result_valid;
    assign bus.running      = r_running;
    assign bus.err_code     = r_err;

endmodule
`default_nettype wire
